// File: rtl/msbs_t3_coef_pipe_buf.sv
// t=3 simplified-Berlekamp key-equation coefficient stage over GF(2^GF_LEN).
// Two-stage pipeline computes {C,B,A,R} and degree flags per syndrome triple;
// results collect into a KEY_EQ_BUF-slot batch released under valid/ack.
module msbs_t3_coef_pipe_buf #(
    parameter int                GF_LEN            = 10,
    parameter logic [GF_LEN-1:0] GF_POLY           = 10'h009,
    parameter int                KEY_EQ_BUF        = 8,
    parameter int                OUT_BUF_DIRECTION = 0
) (
    input  logic                                 clk,
    input  logic                                 in_ctr_Arst,
    input  logic                                 in_ctr_Srst,
    input  logic                                 in_valid,
    output logic                                 out_in_ready,
    input  logic [GF_LEN-1:0]                    in_synd1,
    input  logic [GF_LEN-1:0]                    in_synd3,
    input  logic [GF_LEN-1:0]                    in_synd5,
    input  logic                                 in_flush,
    output logic                                 out_valid,
    input  logic                                 in_ack,
    output logic [4*GF_LEN*KEY_EQ_BUF-1:0]       out_coef,
    output logic [3*KEY_EQ_BUF-1:0]              out_flags,
    output logic [$clog2(KEY_EQ_BUF+1)-1:0]      out_cnt
);

    localparam int CNT_W = $clog2(KEY_EQ_BUF + 1);
    localparam int IDX_W = $clog2(KEY_EQ_BUF);
    localparam int CW    = 4 * GF_LEN;

    typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

    // Polynomial multiply, MSB-first Horner with reduction by the field polynomial.
    function automatic logic [GF_LEN-1:0] gf_mul(input logic [GF_LEN-1:0] a,
                                                 input logic [GF_LEN-1:0] b);
        logic [GF_LEN-1:0] acc;
        acc = '0;
        for (int i = GF_LEN - 1; i >= 0; i--) begin
            acc = {acc[GF_LEN-2:0], 1'b0} ^ (acc[GF_LEN-1] ? GF_POLY : '0);
            if (b[i]) acc = acc ^ a;
        end
        return acc;
    endfunction

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                flush_pend, flush_nxt, clear_buf;
    logic [CNT_W:0]      fill_sum;
    logic                full_wr, accept;
    logic [IDX_W-1:0]    ptr;

    logic [GF_LEN-1:0]   s1sq_p0, s1cu_p0;
    logic                vld_p1, vld_p2;
    logic [GF_LEN-1:0]   s1_p1, s1sq_p1, s1cu_p1, s3_p1, s5_p1;
    logic [GF_LEN-1:0]   a3, c3, b3, r3;
    logic [CW-1:0]       coef_sel, coef_p2;
    logic [2:0]          flags_sel, flags_p2;

    logic [CW-1:0]       coef_mem  [KEY_EQ_BUF];
    logic [2:0]          flags_mem [KEY_EQ_BUF];

    assign accept  = in_valid && out_in_ready;
    assign s1sq_p0 = gf_mul(in_synd1, in_synd1);
    assign s1cu_p0 = gf_mul(s1sq_p0, in_synd1);
    assign full_wr = vld_p2 && (cnt == CNT_W'(KEY_EQ_BUF - 1));
    assign out_cnt = cnt;

    // Stage 1 data: capture syndromes and S1 powers on each accepted beat.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_p1   <= in_synd1;
            s1sq_p1 <= s1sq_p0;
            s1cu_p1 <= s1cu_p0;
            s3_p1   <= in_synd3;
            s5_p1   <= in_synd5;
        end
    end

    // Stage 2 combinational: key-equation terms and degree-based coefficient select.
    always_comb begin
        a3        = gf_mul(s1sq_p1, s3_p1) ^ s5_p1;
        c3        = s1cu_p1 ^ s3_p1;
        b3        = gf_mul(c3, s1_p1);
        r3        = gf_mul(c3, c3) ^ gf_mul(s1_p1, a3);
        coef_sel  = {{GF_LEN{1'b0}}, s1_p1, s1sq_p1, {GF_LEN{1'b0}}};
        flags_sel = {~|(s1_p1 | s3_p1 | s5_p1), |r3, |c3};
        if (|c3) coef_sel = {c3, b3, a3, r3};
    end

    // Stage 2 data register: holds the result one cycle before it lands in a slot.
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            coef_p2  <= coef_sel;
            flags_p2 <= flags_sel;
        end
    end

    // Slot index for the next write depends on fill direction.
    always_comb begin
        if (OUT_BUF_DIRECTION == 0) ptr = IDX_W'(cnt);
        else                        ptr = IDX_W'(KEY_EQ_BUF - 1) - IDX_W'(cnt);
    end

    // Batch controller next-state: fill, drain after flush, hold until ack.
    always_comb begin
        state_nxt    = state;
        flush_nxt    = flush_pend;
        clear_buf    = 1'b0;
        out_in_ready = 1'b0;
        out_valid    = 1'b0;
        fill_sum     = (CNT_W+1)'(cnt) + (CNT_W+1)'(vld_p1) + (CNT_W+1)'(vld_p2);
        case (state)
            FILL: begin
                out_in_ready = (fill_sum < (CNT_W+1)'(KEY_EQ_BUF)) && !flush_pend;
                if (full_wr) begin
                    state_nxt = HOLD;
                end else if (in_flush) begin
                    flush_nxt = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (full_wr) begin
                    state_nxt = HOLD;
                    flush_nxt = 1'b0;
                end else if (!vld_p1 && !vld_p2) begin
                    state_nxt = (cnt != '0) ? HOLD : FILL;
                    flush_nxt = 1'b0;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (in_ack) begin
                    state_nxt = FILL;
                    clear_buf = 1'b1;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Control state, pipeline valids, fill count and slot storage.
    always_ff @(posedge clk or posedge in_ctr_Arst) begin
        if (in_ctr_Arst) begin
            state      <= FILL;
            flush_pend <= 1'b0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            cnt        <= '0;
            for (int i = 0; i < KEY_EQ_BUF; i++) begin
                coef_mem[i]  <= '0;
                flags_mem[i] <= '0;
            end
        end else if (in_ctr_Srst) begin
            state      <= FILL;
            flush_pend <= 1'b0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            cnt        <= '0;
            for (int i = 0; i < KEY_EQ_BUF; i++) begin
                coef_mem[i]  <= '0;
                flags_mem[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            flush_pend <= flush_nxt;
            vld_p1     <= accept;
            vld_p2     <= vld_p1;
            if (clear_buf) begin
                cnt <= '0;
                for (int i = 0; i < KEY_EQ_BUF; i++) begin
                    coef_mem[i]  <= '0;
                    flags_mem[i] <= '0;
                end
            end else if (vld_p2) begin
                cnt            <= cnt + CNT_W'(1);
                coef_mem[ptr]  <= coef_p2;
                flags_mem[ptr] <= flags_p2;
            end
        end
    end

    // Flatten slot storage onto the output buses.
    always_comb begin
        out_coef  = '0;
        out_flags = '0;
        for (int i = 0; i < KEY_EQ_BUF; i++) begin
            out_coef[i*CW +: CW] = coef_mem[i];
            out_flags[i*3 +: 3]  = flags_mem[i];
        end
    end

endmodule

// File: doc/msbs_t3_coef_pipe_buf.md
# msbs_t3_coef_pipe_buf

Parametrised, pipelined successor to the t=3 simplified-Berlekamp (mSBS) key-equation coefficient stage. It takes one syndrome triple (S1, S3, S5) per accepted beat over GF(2^GF_LEN) and computes the error-locator coefficients {C, B, A, R} plus degree flags in a two-stage pipeline. Results are collected into a KEY_EQ_BUF-slot batch buffer, which is released to the parallel Chien search under a valid/ack handshake. New relative to the previous generation:
- generic field width and polynomial
- input backpressure
- partial-batch flush
- a zero-syndrome flag

## Interface
Parameters:
- GF_LEN, 10, field width m.
- GF_POLY, 10'h009, primitive polynomial low bits (x^10+x^3+1); the x^m term is implicit.
- KEY_EQ_BUF, 8, batch slots (≥2).
- OUT_BUF_DIRECTION, 0; 0 = first arrival in slot 0, 1 = first arrival in slot KEY_EQ_BUF-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- in_ctr_Arst  in  1  asynchronous, active-high reset.
- in_ctr_Srst  in  1  synchronous clear; same effect as reset, takes effect at the next edge.
- in_valid  in  1  syndrome triple present.
- out_in_ready  out  1  triple accepted when in_valid && out_in_ready.
- in_synd1 / in_synd3 / in_synd5  in  GF_LEN each  syndromes.
- in_flush  in  1  single-cycle pulse; forces release of a partial batch.
- out_valid  out  1  batch available.
- in_ack  in  1  batch consumed when out_valid && in_ack.
- out_coef  out  4*GF_LEN*KEY_EQ_BUF  slot i is at [i*4*GF_LEN +: 4*GF_LEN], packed {C,B,A,R}.
- out_flags  out  3*KEY_EQ_BUF  slot i is at [i*3 +: 3], packed {zero, deg3_R, deg2_R}.
- out_cnt  out  $clog2(KEY_EQ_BUF+1)  number of filled slots.

## Operation
Arithmetic: all products are GF(2^GF_LEN) polynomial multiplies reduced by GF_POLY; all sums are XOR.

Stage 1 (registered on an accepted beat):
- S1, S1^2, S1^3, S3, S5
- v1 = 1

Stage 2 (combinational from the stage-1 registers):
- A3 = S1^2·S3 ^ S5
- C3 = S1^3 ^ S3
- B3 = C3·S1
- R3 = C3^2 ^ S1·A3
- deg2_R = |C3
- deg3_R = |R3
- zero = ~|(S1|S3|S5)

Coefficient select:
- deg2_R = 1: {C,B,A,R} = {C3, B3, A3, R3}.
- deg2_R = 0: {C,B,A,R} = {0, S1, S1^2, 0}.

Stage 2 is registered with v2; the registered value is written into slot ptr(cnt) on the next edge.
- ptr(k) = k for direction 0; KEY_EQ_BUF-1-k for direction 1.
- cnt increments by 1 on each write.

State machine:
- FILL:
  - out_in_ready = (cnt+v1+v2 < KEY_EQ_BUF) && !flush_pend.
  - A write that makes cnt = KEY_EQ_BUF moves to HOLD.
  - in_flush sets flush_pend and moves to DRAIN.
- DRAIN:
  - out_in_ready = 0.
  - Once v1 = v2 = 0: cnt > 0 moves to HOLD; cnt = 0 returns to FILL.
  - flush_pend clears on either exit.
- HOLD:
  - out_valid = 1; out_in_ready = 0; out_coef, out_flags and out_cnt are frozen.
  - in_ack moves to FILL; all slots clear to 0 and cnt to 0 at the same edge.

Unfilled slots read 0. in_flush is ignored in HOLD. in_flush arriving in the same cycle as the write that fills the buffer: HOLD takes priority and flush_pend is not set.

## Timing
- Reset (async or sync):
  - state FILL; cnt, v1, v2 and flush_pend = 0.
  - all slots, out_coef and out_flags = 0; out_valid = 0.
  - out_in_ready = 1 from the first cycle after reset deasserts.
- Latency: a beat accepted in cycle t is in stage 1 after edge t, in stage 2 after edge t+1, and in its slot after edge t+2.
- A full batch reaches out_valid = 1 in the same cycle that the last slot becomes visible.
- Sustained throughput is 1 beat/cycle until cnt+v1+v2 reaches KEY_EQ_BUF; in-flight beats never overflow the buffer.
- Ack cycle: no input is accepted; out_in_ready = 1 in the next cycle.
- Reset asserted mid-batch discards the pipeline and the buffer; no partial batch is emitted.
- out_in_ready and out_valid are registered-state-derived only; neither depends combinationally on in_valid or in_ack.

## Test plan
- All triples zero (S1=S3=S5=0) ×8 → out_valid rises 2 cycles after the 8th accept. Every slot reads coef 0, flags 3'b100, out_cnt=8.
- Single error at α: S1=10'h002, S3=10'h008, S5=10'h020, ×8 → every slot reads {C,B,A,R}={0,10'h002,10'h004,0}, flags 3'b000.
- S1=10'h001, S3=0, S5=0 → slot reads {C,B,A,R}={1,1,0,1}, flags 3'b011.
- Backpressure: in_valid held high with in_ack low → exactly 8 accepts, out_in_ready low through HOLD. Assert in_ack → out_valid drops, out_cnt=0, a new accept occurs the cycle after ack.
- Flush: 3 beats then in_flush → out_valid with out_cnt=3, slots 3..7 zero. Repeat with OUT_BUF_DIRECTION=1 → first beat lands in slot 7. in_flush with an empty pipeline → no out_valid, returns to FILL.
- Async reset asserted mid-batch (cnt=5, v1=v2=1) → all outputs zero immediately. After release, a fresh 8-beat batch completes with the correct values.
